// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: per-source edge/level latching, enable mask,
// in-service tracking for nesting, and a claim/complete register port driving IRQ.
module irq_controller #(
  parameter int NSRC = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      Addr,
  input  logic            WE,
  input  logic [31:0]     WData,
  output logic [31:0]     RData,
  input  logic [NSRC-1:0] src,
  output logic            IRQ
);

  localparam logic [2:0] A_PEND   = 3'd0;
  localparam logic [2:0] A_EN     = 3'd1;
  localparam logic [2:0] A_EDGE   = 3'd2;
  localparam logic [2:0] A_CLAIM  = 3'd3;
  localparam logic [2:0] A_COMPL  = 3'd4;
  localparam logic [2:0] A_INSERV = 3'd5;

  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] isv_q, isv_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [NSRC-1:0] src_q;
  logic            irq_q;

  logic [NSRC-1:0] claim_sel_s, compl_sel_s, set_s, clr_s, w1c_s, mode_chg_s, cand_s;
  logic [3:0]      cand_id_s;
  logic            blocked_s, found_s;

  // Decode CLAIM/COMPLETE writes into one-hot source selects.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      claim_sel_s[i] = WE && (Addr == A_CLAIM) && (WData == 32'(i + 1)) && pend_q[i];
      compl_sel_s[i] = WE && (Addr == A_COMPL) && (WData == 32'(i + 1));
    end
  end

  // Candidate must be enabled, pending and strictly above the highest-priority in-service source.
  always_comb begin
    blocked_s = 1'b0;
    found_s   = 1'b0;
    cand_id_s = 4'd0;
    cand_s    = '0;
    for (int i = 0; i < NSRC; i++) begin
      blocked_s = blocked_s | isv_q[i];
      cand_s[i] = pend_q[i] & en_q[i] & ~blocked_s;
      if (cand_s[i] && !found_s) begin
        cand_id_s = 4'(i + 1);
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  // Next-state for pending, in-service and configuration registers.
  always_comb begin
    w1c_s      = (WE && (Addr == A_PEND)) ? WData[NSRC-1:0] : '0;
    mode_chg_s = (WE && (Addr == A_EDGE)) ? (WData[NSRC-1:0] ^ edge_q) : '0;
    // A level source being claimed this edge counts as in service, so it does not re-pend.
    for (int i = 0; i < NSRC; i++) begin
      if (edge_q[i]) begin
        set_s[i] = src[i] & ~src_q[i];
      end else begin
        set_s[i] = src[i] & ~isv_q[i] & ~claim_sel_s[i];
      end
    end
    clr_s  = w1c_s | mode_chg_s | claim_sel_s;
    pend_d = set_s | (pend_q & ~clr_s);
    isv_d  = (isv_q | claim_sel_s) & ~compl_sel_s;
    en_d   = (WE && (Addr == A_EN))   ? WData[NSRC-1:0] : en_q;
    edge_d = (WE && (Addr == A_EDGE)) ? WData[NSRC-1:0] : edge_q;
  end

  // Register read mux; unused upper bits read as zero.
  always_comb begin
    case (Addr)
      A_PEND:   RData = 32'(pend_q);
      A_EN:     RData = 32'(en_q);
      A_EDGE:   RData = 32'(edge_q);
      A_CLAIM:  RData = 32'(cand_id_s);
      A_INSERV: RData = 32'(isv_q);
      default:  RData = 32'd0;
    endcase
  end

  // State and registered IRQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      isv_q  <= '0;
      en_q   <= '0;
      edge_q <= '0;
      src_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      isv_q  <= isv_d;
      en_q   <= en_d;
      edge_q <= edge_d;
      src_q  <= src;
      irq_q  <= |cand_s;
    end
  end

  assign IRQ = irq_q;

endmodule
